// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbiter and sequencer for the single-port data memory behind
// the MEM stage. Shares the memory between the EX/MEM load/store request and
// the debug unit's access port, and drives a req/ack handshake to the memory.
// A debug request that has been bypassed for STARVE_LIMIT cycles takes
// priority over the pipeline, so debug waits are bounded.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   pipe_mem_read/_write/_addr/_wdata  EX/MEM access request
//   pipe_rdata, pipe_stall          load data, pipeline freeze (combinational)
//   dbg_req/_we/_addr/_wdata        debug access request (level)
//   dbg_rdata, dbg_done             debug read data, one-cycle completion pulse
//   mem_req/_we/_addr/_wdata        memory request, held until mem_ack
//   mem_rdata, mem_ack              memory read data and completion pulse
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_mem_read,
  input  logic                  pipe_mem_write,
  input  logic [DATA_WIDTH-1:0] pipe_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic [DATA_WIDTH-1:0] pipe_rdata,
  output logic                  pipe_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DATA_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PIPE_BUSY = 3'd1,
    PIPE_DONE = 3'd2,
    DBG_BUSY  = 3'd3,
    DBG_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state;
  state_t     state_next;
  logic [7:0] starve_cnt;
  logic [7:0] starve_next;
  logic       pipe_pending;
  logic       dbg_wins;

  assign pipe_pending = pipe_mem_read | pipe_mem_write;
  // Debug goes first when the pipeline has nothing to do, or when it has
  // already been bypassed long enough.
  assign dbg_wins = dbg_req && ((starve_cnt == LIMIT) || !pipe_pending);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dbg_wins) begin
          state_next = DBG_BUSY;
        end else if (pipe_pending) begin
          state_next = PIPE_BUSY;
        end
      end
      PIPE_BUSY: if (mem_ack) state_next = PIPE_DONE;
      PIPE_DONE: state_next = IDLE;
      DBG_BUSY:  if (mem_ack) state_next = DBG_DONE;
      DBG_DONE:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs decoded from state. mem_req is exactly "in a BUSY state", so it
  // drops the instant reset clears the state register.
  always_comb begin
    mem_req    = (state == PIPE_BUSY) || (state == DBG_BUSY);
    dbg_done   = (state == DBG_DONE);
    pipe_stall = pipe_pending && (state != PIPE_DONE);
  end

  // Starvation counter: counts cycles a debug request waits behind the
  // pipeline, saturating at the limit; cleared when debug is granted.
  always_comb begin
    starve_next = starve_cnt;
    if ((state == IDLE) && dbg_wins) begin
      starve_next = 8'd0;
    end else if (dbg_req && ((state == IDLE) || (state == PIPE_BUSY) ||
                             (state == PIPE_DONE)) && (starve_cnt < LIMIT)) begin
      starve_next = starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else begin
      starve_cnt <= starve_next;
    end
  end

  // Request bus is loaded once on grant and held for the whole handshake;
  // read data is captured on ack, writes included (value is don't-care).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pipe_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      if ((state == IDLE) && dbg_wins) begin
        mem_we    <= dbg_we;
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
      end else if ((state == IDLE) && pipe_pending) begin
        mem_we    <= pipe_mem_write;
        mem_addr  <= pipe_addr;
        mem_wdata <= pipe_wdata;
      end
      if ((state == PIPE_BUSY) && mem_ack) begin
        pipe_rdata <= mem_rdata;
      end
      if ((state == DBG_BUSY) && mem_ack) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reset checks, a table of per-cycle
// vectors for load/store/debug/contention, hand-written starvation and
// mid-access reset sequences, then randomized traffic against a reference
// model that tracks who owns the memory and which phase the access is in.
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_mem_read, pipe_mem_write;
  logic [DW-1:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic          pipe_stall;
  logic          dbg_req, dbg_we;
  logic [DW-1:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic          dbg_done;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ack;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_mem_read(pipe_mem_read), .pipe_mem_write(pipe_mem_write),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One line per completed memory transaction.
  always @(posedge clk) begin
    if (!reset && mem_req && mem_ack)
      $display("txn t=%0t we=%b addr=0x%08h wdata=0x%08h rdata=0x%08h",
               $time, mem_we, mem_addr, mem_wdata, mem_rdata);
  end

  // ---------------- reference model ----------------
  // owner: 0 = memory free, 1 = pipeline, 2 = debug; done marks the
  // single cycle after the ack.
  int          m_owner;
  bit          m_done;
  int          m_starve;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_prdata, m_drdata;

  task automatic model_reset();
    m_owner = 0; m_done = 0; m_starve = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_prdata = '0; m_drdata = '0;
  endtask

  task automatic model_step();
    bit pp, waiting, granted_dbg;
    pp = pipe_mem_read | pipe_mem_write;
    waiting = dbg_req && (m_owner != 2);
    granted_dbg = 0;
    if (m_owner == 0) begin
      if (dbg_req && (m_starve == LIMIT || !pp)) begin
        m_owner = 2; m_done = 0; granted_dbg = 1;
        m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
      end else if (pp) begin
        m_owner = 1; m_done = 0;
        m_we = pipe_mem_write; m_addr = pipe_addr; m_wdata = pipe_wdata;
      end
    end else if (!m_done) begin
      if (mem_ack) begin
        if (m_owner == 1) m_prdata = mem_rdata;
        else              m_drdata = mem_rdata;
        m_done = 1;
      end
    end else begin
      m_owner = 0; m_done = 0;
    end
    if (granted_dbg)                        m_starve = 0;
    else if (waiting && m_starve < LIMIT)   m_starve = m_starve + 1;
  endtask

  task automatic check_model();
    bit pp;
    pp = pipe_mem_read | pipe_mem_write;
    chk1 ("rnd_stall",  pipe_stall, pp && !(m_owner == 1 && m_done));
    chk1 ("rnd_req",    mem_req,    (m_owner != 0) && !m_done);
    chk1 ("rnd_done",   dbg_done,   (m_owner == 2) && m_done);
    chk1 ("rnd_we",     mem_we,     m_we);
    chk32("rnd_addr",   mem_addr,   m_addr);
    chk32("rnd_wdata",  mem_wdata,  m_wdata);
    chk32("rnd_prdata", pipe_rdata, m_prdata);
    chk32("rnd_drdata", dbg_rdata,  m_drdata);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd, wr, dreq, dwe, ack;
    logic [31:0] paddr, pwdata, daddr, mrdata;
    logic        e_stall, e_req, e_we, e_done;
    logic [31:0] e_addr, e_wdata, e_prdata, e_drdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic rd, wr, dreq, dwe, ack,
    input logic [31:0] paddr, pwdata, daddr, mrdata,
    input logic e_stall, e_req, e_we, e_done,
    input logic [31:0] e_addr, e_wdata, e_prdata, e_drdata);
    vec_t r;
    r.rd = rd; r.wr = wr; r.dreq = dreq; r.dwe = dwe; r.ack = ack;
    r.paddr = paddr; r.pwdata = pwdata; r.daddr = daddr; r.mrdata = mrdata;
    r.e_stall = e_stall; r.e_req = e_req; r.e_we = e_we; r.e_done = e_done;
    r.e_addr = e_addr; r.e_wdata = e_wdata; r.e_prdata = e_prdata; r.e_drdata = e_drdata;
    return r;
  endfunction

  initial begin
    logic [31:0] dd, ss, aa, cc, p1, p2;
    int          grant_cyc, pipe_grants;
    bit          prev_req, done_seen;

    dd = 32'hDEADBEEF; ss = 32'h12345678; aa = 32'hAAAA5555;
    cc = 32'hCAFEF00D; p1 = 32'h11111111; p2 = 32'h22222222;

    // rd wr dreq dwe ack paddr pwdata daddr mrdata | stall req we done addr wdata prdata drdata
    // single load, ack in first req cycle
    vecs.push_back(v(1,0,0,0,0, 32'h10,0,0,0,   1,0,0,0, 0,0,0,0));
    vecs.push_back(v(1,0,0,0,1, 32'h10,0,0,dd,  1,1,0,0, 32'h10,0,0,0));
    vecs.push_back(v(1,0,0,0,0, 32'h10,0,0,0,   0,0,0,0, 32'h10,0,dd,0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,        0,0,0,0, 32'h10,0,dd,0));
    // store, ack after 3 extra cycles
    vecs.push_back(v(0,1,0,0,0, 32'h20,ss,0,0,  1,0,0,0, 32'h10,0,dd,0));
    vecs.push_back(v(0,1,0,0,0, 32'h20,ss,0,0,  1,1,1,0, 32'h20,ss,dd,0));
    vecs.push_back(v(0,1,0,0,0, 32'h20,ss,0,0,  1,1,1,0, 32'h20,ss,dd,0));
    vecs.push_back(v(0,1,0,0,0, 32'h20,ss,0,0,  1,1,1,0, 32'h20,ss,dd,0));
    vecs.push_back(v(0,1,0,0,1, 32'h20,ss,0,aa, 1,1,1,0, 32'h20,ss,dd,0));
    vecs.push_back(v(0,1,0,0,0, 32'h20,ss,0,0,  0,0,1,0, 32'h20,ss,aa,0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,        0,0,1,0, 32'h20,ss,aa,0));
    // debug read with pipeline idle
    vecs.push_back(v(0,0,1,0,0, 0,0,32'h40,0,   0,0,1,0, 32'h20,ss,aa,0));
    vecs.push_back(v(0,0,1,0,1, 0,0,32'h40,cc,  0,1,0,0, 32'h40,0,aa,0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,        0,0,0,1, 32'h40,0,aa,cc));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,        0,0,0,0, 32'h40,0,aa,cc));
    // simultaneous load and debug, starve count 0: pipeline first
    vecs.push_back(v(1,0,1,0,0, 32'h50,0,32'h60,0,  1,0,0,0, 32'h40,0,aa,cc));
    vecs.push_back(v(1,0,1,0,1, 32'h50,0,32'h60,p1, 1,1,0,0, 32'h50,0,aa,cc));
    vecs.push_back(v(1,0,1,0,0, 32'h50,0,32'h60,0,  0,0,0,0, 32'h50,0,p1,cc));
    vecs.push_back(v(0,0,1,0,0, 0,0,32'h60,0,       0,0,0,0, 32'h50,0,p1,cc));
    vecs.push_back(v(0,0,1,0,1, 0,0,32'h60,p2,      0,1,0,0, 32'h60,0,p1,cc));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,            0,0,0,1, 32'h60,0,p1,p2));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,            0,0,0,0, 32'h60,0,p1,p2));

    // ---------------- reset ----------------
    reset = 1'b1;
    pipe_mem_read = 0; pipe_mem_write = 0; pipe_addr = '0; pipe_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk1 ("rst_req",    mem_req,    1'b0);
    chk1 ("rst_we",     mem_we,     1'b0);
    chk32("rst_addr",   mem_addr,   32'h0);
    chk32("rst_wdata",  mem_wdata,  32'h0);
    chk32("rst_prdata", pipe_rdata, 32'h0);
    chk32("rst_drdata", dbg_rdata,  32'h0);
    chk1 ("rst_done",   dbg_done,   1'b0);
    chk1 ("rst_stall0", pipe_stall, 1'b0);
    pipe_mem_read = 1; #1;
    chk1 ("rst_stall1", pipe_stall, 1'b1);
    pipe_mem_read = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      pipe_mem_read = vecs[i].rd; pipe_mem_write = vecs[i].wr;
      pipe_addr = vecs[i].paddr; pipe_wdata = vecs[i].pwdata;
      dbg_req = vecs[i].dreq; dbg_we = vecs[i].dwe;
      dbg_addr = vecs[i].daddr; dbg_wdata = '0;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].mrdata;
      #1;
      chk1 ($sformatf("vec%0d_stall", i),  pipe_stall, vecs[i].e_stall);
      chk1 ($sformatf("vec%0d_req", i),    mem_req,    vecs[i].e_req);
      chk1 ($sformatf("vec%0d_we", i),     mem_we,     vecs[i].e_we);
      chk1 ($sformatf("vec%0d_done", i),   dbg_done,   vecs[i].e_done);
      chk32($sformatf("vec%0d_addr", i),   mem_addr,   vecs[i].e_addr);
      chk32($sformatf("vec%0d_wdata", i),  mem_wdata,  vecs[i].e_wdata);
      chk32($sformatf("vec%0d_prdata", i), pipe_rdata, vecs[i].e_prdata);
      chk32($sformatf("vec%0d_drdata", i), dbg_rdata,  vecs[i].e_drdata);
      @(posedge clk); #1;
    end

    // ---------------- starvation: continuous loads, debug held ----------------
    pipe_mem_read = 1; pipe_mem_write = 0; pipe_addr = 32'h70; pipe_wdata = '0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h80;
    grant_cyc = -1; pipe_grants = 0; prev_req = 0; done_seen = 0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      mem_ack = mem_req;
      mem_rdata = 32'h0BAD0000 + 32'(c);
      #1;
      if (mem_req && !prev_req) begin
        if (mem_addr == 32'h80) begin
          grant_cyc = c;
          chk1("starve_stall_in_dbg", pipe_stall, 1'b1);
        end else begin
          pipe_grants++;
        end
      end
      prev_req = mem_req;
      if (dbg_done) begin
        done_seen = 1;
        chk1 ("starve_stall_at_done", pipe_stall, 1'b1);
        chk32("starve_drdata", dbg_rdata, 32'h0BAD000A);
        dbg_req = 0; pipe_mem_read = 0;
      end
      @(posedge clk); #1;
    end
    mem_ack = 0;
    chk1 ("starve_done_seen", done_seen, 1'b1);
    chk32("starve_grant_cycle", 32'(grant_cyc), 32'd10);
    chk32("starve_pipe_grants", 32'(pipe_grants), 32'd3);

    // ---------------- reset during PIPE_BUSY, late ack ----------------
    pipe_mem_read = 1; pipe_addr = 32'h90;
    @(posedge clk); #1;
    chk1("rb_req_before", mem_req, 1'b1);
    #2;
    reset = 1'b1; pipe_mem_read = 0;
    #1;
    chk1 ("rb_req",    mem_req,    1'b0);
    chk1 ("rb_we",     mem_we,     1'b0);
    chk32("rb_addr",   mem_addr,   32'h0);
    chk32("rb_prdata", pipe_rdata, 32'h0);
    chk32("rb_drdata", dbg_rdata,  32'h0);
    chk1 ("rb_done",   dbg_done,   1'b0);
    chk1 ("rb_stall",  pipe_stall, 1'b0);
    @(negedge clk); reset = 1'b0;
    mem_ack = 1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_ack = 0;
    chk1 ("rb_late_req",    mem_req,    1'b0);
    chk32("rb_late_prdata", pipe_rdata, 32'h0);
    @(posedge clk); #1;
    chk1 ("rb_idle_req",    mem_req,    1'b0);
    chk32("rb_idle_prdata", pipe_rdata, 32'h0);

    // ---------------- randomized traffic vs model ----------------
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      pipe_mem_read  = ($urandom_range(0, 99) < ((c < 750) ? 80 : 35));
      pipe_mem_write = ($urandom_range(0, 99) < 25);
      pipe_addr = $urandom; pipe_wdata = $urandom;
      if (dbg_done)      dbg_req = ($urandom_range(0, 3) == 0);
      else if (!dbg_req) dbg_req = ($urandom_range(0, 5) == 0);
      dbg_we = ($urandom_range(0, 1) == 1);
      dbg_addr = $urandom; dbg_wdata = $urandom;
      mem_ack = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      #1;
      check_model();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
